shift_sequencer: RTL and testbench

Sequencing controller for the 8-bit `serialByteShift` single-step shifter. It accepts a multi-bit shift request over a valid/ready handshake and owns one `serialByteShift` instance. It applies one single-bit step per clock until the requested amount is consumed, then presents the result and the last bit shifted out on a valid/ready output. It sits between the ALU operation decoder and the ALU result mux, and turns the combinational one-bit shifter into logical, arithmetic and rotate shifts of 0..2^AMT_W-1 positions.

---
 rtl/shift_sequencer.sv | 142 ++++++++++++++
 tb/tb_shift_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer (with serialByteShift)
// Purpose  : Multi-step logical/arithmetic/rotate shifter built from a
//            single-step 8-bit shifter, with valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================

module serialByteShift (
    input  logic [7:0] d_i,
    input  logic       s0_i,
    input  logic       sr_i,
    input  logic       sl_i,
    output logic [7:0] q_o
);
    // s0_i=0 moves bits toward the MSB (fill at bit 0), s0_i=1 toward the LSB.
    assign q_o = s0_i ? {sl_i, d_i[7:1]} : {d_i[6:0], sr_i};
endmodule

module shift_sequencer #(
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_data,
    input  logic [AMT_W-1:0] req_amt,
    input  logic             req_dir,
    input  logic [1:0]       req_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_carry
);
    localparam logic [1:0]       MODE_ARITH = 2'b01;
    localparam logic [1:0]       MODE_ROT   = 2'b10;
    localparam logic [AMT_W-1:0] CNT_ZERO   = '0;
    localparam logic [AMT_W-1:0] CNT_ONE    = AMT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [7:0]       work_q;
    logic             carry_q;
    logic [AMT_W-1:0] cnt_q;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic             out_valid_q;
    logic             req_ready_q;

    logic             out_bit_d;
    logic             fill_d;
    logic             sr_d;
    logic             sl_d;
    logic [7:0]       work_d;

    assign out_bit_d = dir_q ? work_q[0] : work_q[7];

    always_comb begin
        fill_d = 1'b0;
        if (mode_q == MODE_ROT) begin
            fill_d = out_bit_d;
        end else if (mode_q == MODE_ARITH && dir_q) begin
            fill_d = work_q[7];
        end
    end

    // Only the input on the fill side of the current direction is driven.
    assign sr_d = dir_q ? 1'b0 : fill_d;
    assign sl_d = dir_q ? fill_d : 1'b0;

    serialByteShift u_shifter (
        .d_i  (work_q),
        .s0_i (dir_q),
        .sr_i (sr_d),
        .sl_i (sl_d),
        .q_o  (work_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            work_q      <= 8'h00;
            carry_q     <= 1'b0;
            cnt_q       <= CNT_ZERO;
            dir_q       <= 1'b0;
            mode_q      <= 2'b00;
            out_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        work_q      <= req_data;
                        cnt_q       <= req_amt;
                        dir_q       <= req_dir;
                        mode_q      <= req_mode;
                        carry_q     <= 1'b0;
                        req_ready_q <= 1'b0;
                        state_q     <= (req_amt == CNT_ZERO) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work_q  <= work_d;
                    carry_q <= out_bit_d;
                    cnt_q   <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // out_valid is raised one edge after entering DONE and
                    // held with the result until the consumer takes it.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = work_q;
    assign out_carry = carry_q;
endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Self-checking bench for shift_sequencer against a shift model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_shift_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;
    logic [2:0] req_amt;
    logic       req_dir;
    logic [1:0] req_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_carry;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.AMT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_dir   (req_dir),
        .req_mode  (req_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry)
    );

    // Whole-word shift model: returns {carry, result}.
    function automatic logic [8:0] model(input logic [7:0] d, input logic [2:0] amt,
                                         input logic dir, input logic [1:0] mode);
        logic [15:0] t;
        logic [7:0]  r;
        logic        c;
        if (mode == 2'b10) begin
            if (!dir) begin
                t = {d, d} << amt;
                r = t[15:8];
                c = (amt != 0) ? r[0] : 1'b0;
            end else begin
                t = {d, d} >> amt;
                r = t[7:0];
                c = (amt != 0) ? r[7] : 1'b0;
            end
        end else if (dir) begin
            if (mode == 2'b01) t = $signed({d, 8'h00}) >>> amt;
            else               t = {d, 8'h00} >> amt;
            r = t[15:8];
            c = (amt != 0) ? t[7] : 1'b0;
        end else begin
            t = {8'h00, d} << amt;
            r = t[7:0];
            c = (amt != 0) ? t[8] : 1'b0;
        end
        return {c, r};
    endfunction

    // Issues one request, scrambles the request inputs after acceptance,
    // and returns the result plus edges from acceptance to out_valid.
    task automatic do_op(input logic [7:0] d, input logic [2:0] amt, input logic dir,
                         input logic [1:0] mode, input int hold,
                         output logic [7:0] r, output logic c, output int lat);
        int g = 0;
        while (!req_ready && g < 50) begin
            @(posedge clk); #1; g++;
        end
        if (!req_ready) begin
            tests_run++; fails++;
            $display("FAIL req_ready_timeout: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; req_data = d; req_amt = amt; req_dir = dir; req_mode = mode;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_data = 8'($urandom); req_amt = 3'($urandom);
        req_dir = 1'($urandom); req_mode = 2'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin
            tests_run++; fails++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
        end
        r = out_data;
        c = out_carry;
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({req_ready, out_valid, out_data, out_carry} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h carry=%b required 1 0 00 0",
                     req_ready, out_valid, out_data, out_carry);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed(input string name, input logic [7:0] d, input logic [2:0] amt,
                                 input logic dir, input logic [1:0] mode,
                                 input logic [7:0] exp_r, input logic exp_c);
        logic [7:0] r; logic c; int lat;
        do_op(d, amt, dir, mode, 0, r, c, lat);
        tests_run++;
        if ({c, r} !== {exp_c, exp_r}) begin
            fails++;
            $display("FAIL %s: data=%h carry=%b required data=%h carry=%b", name, r, c, exp_r, exp_c);
        end
        tests_run++;
        if (lat !== int'(amt) + 1) begin
            fails++;
            $display("FAIL %s_latency: %0d edges required %0d", name, lat, int'(amt) + 1);
        end
        tests_run++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_release: vld=%b rdy=%b required 0 1", name, out_valid, req_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held_d; logic held_c; logic [8:0] exp;
        logic [7:0] r; logic c; int lat;
        req_valid = 1'b1; req_data = 8'hC3; req_amt = 3'd2; req_dir = 1'b1; req_mode = 2'b01;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        held_d = out_data; held_c = out_carry;
        tests_run++;
        if ({held_c, held_d} !== model(8'hC3, 3'd2, 1'b1, 2'b01)) begin
            fails++;
            $display("FAIL bp_result: data=%h carry=%b required %h", held_d, held_c,
                     model(8'hC3, 3'd2, 1'b1, 2'b01));
        end
        for (int i = 0; i < 5; i++) begin
            req_valid = i[0] ? 1'b0 : 1'b1;
            req_data = 8'h5A; req_amt = 3'd3; req_dir = 1'b0; req_mode = 2'b10;
            @(posedge clk); #1;
            tests_run++;
            if ({out_valid, req_ready, out_data, out_carry} !== {1'b1, 1'b0, held_d, held_c}) begin
                fails++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b data=%h carry=%b required 1 0 %h %b",
                         i, out_valid, req_ready, out_data, out_carry, held_d, held_c);
            end
        end
        req_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_idle: vld=%b rdy=%b required 0 1", out_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests_run++;
        if (req_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_accept: rdy=%b required 0", req_ready);
        end
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        r = out_data; c = out_carry;
        exp = model(8'h5A, 3'd3, 1'b0, 2'b10);
        tests_run++;
        if ({c, r} !== exp || lat !== 4) begin
            fails++;
            $display("FAIL bp_held_req: data=%h carry=%b lat=%0d required %h lat=4", r, c, lat, exp);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] r; logic c; int lat;
        req_valid = 1'b1; req_data = 8'h96; req_amt = 3'd6; req_dir = 1'b0; req_mode = 2'b10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests_run++;
        if ({req_ready, out_valid, out_data, out_carry} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid: rdy=%b vld=%b data=%h carry=%b required 1 0 00 0",
                     req_ready, out_valid, out_data, out_carry);
        end
        do_op(8'h01, 3'd1, 1'b0, 2'b00, 0, r, c, lat);
        tests_run++;
        if ({c, r} !== {1'b0, 8'h02} || lat !== 2) begin
            fails++;
            $display("FAIL reset_mid_after: data=%h carry=%b lat=%0d required 02 0 lat=2", r, c, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] d, r; logic [2:0] amt; logic dir, c; logic [1:0] mode;
        logic [8:0] exp; int lat;
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom); amt = 3'($urandom); dir = 1'($urandom); mode = 2'($urandom);
            exp = model(d, amt, dir, mode);
            do_op(d, amt, dir, mode, int'($urandom_range(0, 3)), r, c, lat);
            tests_run++;
            if ({c, r} !== exp || lat !== int'(amt) + 1) begin
                fails++;
                $display("FAIL rand%0d: d=%h amt=%0d dir=%b mode=%b got %h/%b lat=%0d required %h/%b lat=%0d",
                         i, d, amt, dir, mode, r, c, lat, exp[7:0], exp[8], int'(amt) + 1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_data = 8'h00; req_amt = 3'd0;
        req_dir = 1'b0; req_mode = 2'b00; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed("arith",      8'b1001_0110, 3'd3, 1'b1, 2'b01, 8'b1111_0010, 1'b1);
        test_directed("rotate_msb", 8'hA5,        3'd5, 1'b0, 2'b10, 8'hB4,        1'b0);
        test_directed("logical",    8'hFF,        3'd7, 1'b0, 2'b00, 8'h80,        1'b1);
        test_directed("reserved",   8'hFF,        3'd7, 1'b0, 2'b11, 8'h80,        1'b1);
        test_directed("zero_amt",   8'h3C,        3'd0, 1'b1, 2'b10, 8'h3C,        1'b0);
        test_directed("rotate_lsb", 8'h81,        3'd1, 1'b1, 2'b10, 8'hC0,        1'b1);
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

`default_nettype wire
